// File: rtl/xorer_pkg.sv
// Shared definitions for the xor_arbiter slice.
//   XOR_WIDTH    default data/key width
//   MAX_ID_W     widest requester index (up to 8 requesters)
//   clog2_min1   index width helper, never returns less than 1
//   key_wr_cmd_t key-write command bundle {en, idx, data} at default widths
package xorer_pkg;

  localparam int XOR_WIDTH = 32;
  localparam int MAX_ID_W  = 3;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                 en;
    logic [MAX_ID_W-1:0]  idx;
    logic [XOR_WIDTH-1:0] data;
  } key_wr_cmd_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered "last granted" pointer.
//   clk, rst   clock and synchronous active-high reset
//   req        request vector
//   advance    pulse when the current grant is consumed; moves the pointer
//   grant      one-hot grant (zero when no request)
//   grant_idx  binary index of the grant (zero when no request)
module rr_arbiter
  import xorer_pkg::*;
#(
  parameter int N    = 2,
  parameter int ID_W = clog2_min1(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_idx
);

  logic [ID_W-1:0] last_q;
  logic [ID_W-1:0] last_d;
  logic            found;

  // Search starts one past the last winner and wraps, so the previous
  // winner drops to lowest priority.
  always_comb begin
    int j_idx;
    j_idx     = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= N; k++) begin
      j_idx = (int'(last_q) + k) % N;
      if (!found && req[j_idx]) begin
        found     = 1'b1;
        grant_idx = ID_W'(j_idx);
      end
    end
    grant = '0;
    if (found) grant[grant_idx] = 1'b1;
  end

  always_comb begin
    last_d = last_q;
    if (advance && found) last_d = grant_idx;
  end

  // Reset to N-1 so requester 0 is searched first.
  always_ff @(posedge clk) begin
    if (rst) last_q <= ID_W'(N - 1);
    else     last_q <= last_d;
  end

endmodule

// File: rtl/xor_arbiter.sv
// Shared registered XOR datapath for N_REQ requesters.
//   key_wr_*    per-requester key write port (out-of-range index ignored)
//   req_valid/req_data/req_ready  requester handshakes, word i at [i*WIDTH +: WIDTH]
//   out_valid/out_data/out_id/out_ready  1-deep output register handshake
// The accepted word is XORed with its requester's key and registered with
// the requester id. Accept and drain may coincide for 1 word/cycle.
module xor_arbiter
  import xorer_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int WIDTH = XOR_WIDTH,
  parameter int ID_W  = clog2_min1(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   key_wr_en,
  input  logic [ID_W-1:0]        key_wr_idx,
  input  logic [WIDTH-1:0]       key_wr_data,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [ID_W-1:0]        out_id,
  input  logic                   out_ready
);

  logic [WIDTH-1:0] key_q  [N_REQ];
  logic [WIDTH-1:0] masked [N_REQ];
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;
  logic [WIDTH-1:0] sel_word;
  logic             can_accept;
  logic             accept;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [ID_W-1:0]  out_id_q,    out_id_d;

  rr_arbiter #(
    .N    (N_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign can_accept = !out_valid_q || out_ready;
  assign req_ready  = (rst || !can_accept) ? '0 : grant;
  // grant only ever covers a valid requester, so any ready bit is an accept.
  assign accept     = |req_ready;

  // Key registers read their pre-edge value, so a same-cycle write to the
  // granted index only affects later accepts.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
      assign masked[gi] = grant[gi] ? (req_data[gi*WIDTH +: WIDTH] ^ key_q[gi]) : '0;

      always_ff @(posedge clk) begin
        if (rst)                                          key_q[gi] <= '0;
        else if (key_wr_en && key_wr_idx == ID_W'(gi))    key_q[gi] <= key_wr_data;
      end
    end
  endgenerate

  // One-hot AND-OR mux over the masked words.
  always_comb begin
    sel_word = '0;
    for (int i = 0; i < N_REQ; i++) sel_word = sel_word | masked[i];
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_word;
      out_id_d    = grant_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;

endmodule

// File: tb/tb_xor_arbiter.sv
module tb_xor_arbiter;

  localparam int N  = 3;
  localparam int W  = 32;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           key_wr_en;
  logic [IW-1:0]  key_wr_idx;
  logic [W-1:0]   key_wr_data;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [IW-1:0]  out_id;
  logic           out_ready;

  int checks = 0;
  int errors = 0;

  xor_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk         (clk),
    .rst         (rst),
    .key_wr_en   (key_wr_en),
    .key_wr_idx  (key_wr_idx),
    .key_wr_data (key_wr_data),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_id      (out_id),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: keys, last winner, and the output register contents.
  logic [W-1:0] m_key [N];
  int           m_last;
  bit           m_ov;
  logic [W-1:0] m_od;
  int           m_oid;

  function automatic int m_grant();
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_last + k) % N;
      if (req_valid[j]) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] m_ready();
    logic [N-1:0] r;
    int g;
    r = '0;
    g = m_grant();
    if (!rst && g >= 0 && (!m_ov || out_ready)) r[g] = 1'b1;
    return r;
  endfunction

  // Requester obligation: a valid word that was not accepted stays put.
  logic [N-1:0]   prev_v, prev_r;
  logic [N*W-1:0] prev_d;
  logic           prev_rst = 1'b1;
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (!prev_rst && prev_v[i] && !prev_r[i])
        assert (req_valid[i] && req_data[i*W +: W] == prev_d[i*W +: W])
          else $error("requester %0d dropped or changed an unaccepted word", i);
    end
    prev_v   <= req_valid;
    prev_r   <= req_ready;
    prev_d   <= req_data;
    prev_rst <= rst;
  end

  task automatic drive(input bit r, input logic [N-1:0] v, input logic [W-1:0] d0,
                       input logic [W-1:0] d1, input logic [W-1:0] d2, input bit ordy,
                       input bit kwe, input logic [IW-1:0] kidx, input logic [W-1:0] kd);
    @(negedge clk);
    rst         = r;
    req_valid   = v;
    req_data    = {d2, d1, d0};
    out_ready   = ordy;
    key_wr_en   = kwe;
    key_wr_idx  = kidx;
    key_wr_data = kd;
    #1;
  endtask

  task automatic tick();
    int g;
    bit can;
    @(posedge clk);
    if (rst) begin
      m_ov = 0; m_od = '0; m_oid = 0; m_last = N - 1;
      for (int i = 0; i < N; i++) m_key[i] = '0;
    end else begin
      can = !m_ov || out_ready;
      g   = m_grant();
      if (can && g >= 0) begin
        m_od = req_data[g*W +: W] ^ m_key[g];
        m_oid = g; m_ov = 1; m_last = g;
      end else if (m_ov && out_ready) begin
        m_ov = 0;
      end
      if (key_wr_en && key_wr_idx < N) m_key[key_wr_idx] = key_wr_data;
    end
    #1;
  endtask

  task automatic idle();
    drive(0, '0, '0, '0, '0, 1, 0, '0, '0);
    tick();
  endtask

  task automatic test_reset();
    drive(1, 3'b111, 32'h1, 32'h2, 32'h3, 1, 0, '0, '0);
    checks++;
    if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got %b want 000", req_ready); end
    tick();
    drive(1, '0, '0, '0, '0, 1, 0, '0, '0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_id !== '0) begin
      errors++; $display("FAIL reset_out got v=%b d=%h id=%0d want v=0 d=0 id=0", out_valid, out_data, out_id);
    end
  endtask

  task automatic test_passthrough();
    drive(0, 3'b001, 32'hDEADBEEF, '0, '0, 1, 0, '0, '0);
    checks++;
    if (req_ready !== 3'b001) begin errors++; $display("FAIL pass_ready got %b want 001", req_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF || out_id !== 2'd0) begin
      errors++; $display("FAIL pass_out got v=%b d=%h id=%0d want v=1 d=deadbeef id=0", out_valid, out_data, out_id);
    end
    idle();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL pass_drain got v=%b want 0", out_valid); end
  endtask

  task automatic test_keyed();
    drive(0, '0, '0, '0, '0, 1, 1, 2'd1, 32'hFFFF0000);
    tick();
    drive(0, 3'b010, '0, 32'h12345678, '0, 1, 0, '0, '0);
    checks++;
    if (req_ready !== 3'b010) begin errors++; $display("FAIL keyed_ready got %b want 010", req_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hEDCB5678 || out_id !== 2'd1) begin
      errors++; $display("FAIL keyed_out got v=%b d=%h id=%0d want v=1 d=edcb5678 id=1", out_valid, out_data, out_id);
    end
  endtask

  task automatic test_round_robin();
    int seq [4] = '{0, 1, 0, 1};
    logic [W-1:0] a, b;
    a = 32'hA5A5_0001;
    b = 32'h5A5A_0002;
    drive(0, '0, '0, '0, '0, 1, 1, 2'd1, '0);   // clear key1, drain keyed result
    tick();
    for (int c = 0; c < 4; c++) begin
      drive(0, 3'b011, a, b, '0, 1, 0, '0, '0);
      checks++;
      if (req_ready !== (3'b001 << seq[c])) begin
        errors++; $display("FAIL rr_ready[%0d] got %b want one-hot %0d", c, req_ready, seq[c]);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_id !== IW'(seq[c]) || out_data !== (seq[c] == 0 ? a : b)) begin
        errors++; $display("FAIL rr_out[%0d] got v=%b id=%0d d=%h want v=1 id=%0d", c, out_valid, out_id, out_data, seq[c]);
      end
    end
    drive(0, 3'b001, a, '0, '0, 1, 0, '0, '0);  // retire the pending req0 word
    tick();
    idle();
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b;
    a = 32'h0BAD_F00D;
    b = 32'h1357_9BDF;
    drive(0, 3'b001, a, '0, '0, 1, 0, '0, '0);
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(0, 3'b010, '0, b, '0, 0, 0, '0, '0);
      checks++;
      if (req_ready !== 3'b000) begin errors++; $display("FAIL bp_ready[%0d] got %b want 000", c, req_ready); end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== a || out_id !== 2'd0) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b d=%h id=%0d want v=1 d=%h id=0", c, out_valid, out_data, out_id, a);
      end
    end
    drive(0, 3'b010, '0, b, '0, 1, 0, '0, '0);
    checks++;
    if (req_ready !== 3'b010) begin errors++; $display("FAIL bp_release_ready got %b want 010", req_ready); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== b || out_id !== 2'd1) begin
      errors++; $display("FAIL bp_reload got v=%b d=%h id=%0d want v=1 d=%h id=1", out_valid, out_data, out_id, b);
    end
    idle();
  endtask

  task automatic test_same_cycle_key();
    drive(0, '0, '0, '0, '0, 1, 1, 2'd0, 32'h0000000F);
    tick();
    drive(0, 3'b001, '0, '0, '0, 1, 1, 2'd0, 32'hF0000000);
    tick();
    checks++;
    if (out_data !== 32'h0000000F) begin errors++; $display("FAIL samekey_old got %h want 0000000f", out_data); end
    drive(0, 3'b001, '0, '0, '0, 1, 0, '0, '0);
    tick();
    checks++;
    if (out_data !== 32'hF0000000) begin errors++; $display("FAIL samekey_new got %h want f0000000", out_data); end
    idle();
  endtask

  task automatic test_key_oob();
    drive(0, '0, '0, '0, '0, 1, 1, 2'd3, 32'h55555555);
    tick();
    drive(0, 3'b001, '0, '0, '0, 1, 0, '0, '0);
    tick();
    checks++;
    if (out_data !== 32'hF0000000) begin errors++; $display("FAIL oob_key0 got %h want f0000000", out_data); end
    drive(0, 3'b100, '0, '0, '0, 1, 0, '0, '0);
    tick();
    checks++;
    if (out_data !== 32'h0 || out_id !== 2'd2) begin
      errors++; $display("FAIL oob_key2 got d=%h id=%0d want d=0 id=2", out_data, out_id);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] x, y;
    x = 32'hCAFE_0000;
    y = 32'h0000_BABE;
    drive(0, 3'b001, x, '0, '0, 0, 0, '0, '0);
    tick();
    drive(1, '0, '0, '0, '0, 0, 0, '0, '0);
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_id !== '0) begin
      errors++; $display("FAIL rstmid_out got v=%b d=%h id=%0d want v=0 d=0 id=0", out_valid, out_data, out_id);
    end
    drive(0, 3'b011, x, y, '0, 1, 0, '0, '0);
    checks++;
    if (req_ready !== 3'b001) begin errors++; $display("FAIL rstmid_ptr got %b want 001", req_ready); end
    tick();
    checks++;
    if (out_data !== x || out_id !== 2'd0) begin
      errors++; $display("FAIL rstmid_key0 got d=%h id=%0d want d=%h id=0", out_data, out_id, x);
    end
    drive(0, 3'b010, '0, y, '0, 1, 0, '0, '0);
    tick();
    idle();
  endtask

  task automatic test_random();
    bit           pend [N];
    logic [W-1:0] pd   [N];
    logic [N-1:0] v, rdy, exp_r;
    for (int i = 0; i < N; i++) begin pend[i] = 0; pd[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      v = '0;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin pend[i] = 1; pd[i] = $urandom; end
        v[i] = pend[i];
      end
      drive($urandom_range(0, 63) == 0, v, pd[0], pd[1], pd[2], $urandom_range(0, 3) != 0,
            $urandom_range(0, 3) == 0, IW'($urandom_range(0, 3)), $urandom);
      exp_r = m_ready();
      rdy   = req_ready;
      checks++;
      if (rdy !== exp_r) begin errors++; $display("FAIL rand_ready[%0d] got %b want %b", c, rdy, exp_r); end
      tick();
      checks++;
      if (out_valid !== m_ov || out_data !== m_od || out_id !== IW'(m_oid)) begin
        errors++;
        $display("FAIL rand_out[%0d] got v=%b d=%h id=%0d want v=%b d=%h id=%0d",
                 c, out_valid, out_data, out_id, m_ov, m_od, m_oid);
      end
      for (int i = 0; i < N; i++) if (rdy[i]) pend[i] = 0;
    end
  endtask

  initial begin
    rst = 1; key_wr_en = 0; key_wr_idx = '0; key_wr_data = '0;
    req_valid = '0; req_data = '0; out_ready = 1;
    m_ov = 0; m_od = '0; m_oid = 0; m_last = N - 1;
    for (int i = 0; i < N; i++) m_key[i] = '0;
    test_reset();
    test_passthrough();
    test_keyed();
    test_round_robin();
    test_backpressure();
    test_same_cycle_key();
    test_key_oob();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
